// File: rtl/tnoc_stream_demux_pkg.sv
// Shared types and helpers for the stream demultiplexer.
package tnoc_stream_demux_pkg;

   localparam int unsigned MaxEntries = 32;

   typedef enum logic [1:0] {
      StIdle  = 2'd0,
      StRoute = 2'd1,
      StDrop  = 2'd2
   } demux_state_e;

   // True when exactly one bit of v is set.
   function automatic logic is_onehot(input logic [MaxEntries-1:0] v);
      return (v != '0) && ((v & (v - 32'd1)) == '0);
   endfunction

endpackage

// File: rtl/tnoc_demux_slot.sv
// One-entry output register for a single demux channel; empty slots present DEFAULT.
module tnoc_demux_slot #(
   parameter int unsigned     WIDTH   = 8,
   parameter bit [WIDTH-1:0]  DEFAULT = '0
) (
   input  logic             i_clk,
   input  logic             i_rst,
   input  logic             i_load,
   input  logic [WIDTH-1:0] i_value,
   input  logic             i_ready,
   output logic             o_valid,
   output logic [WIDTH-1:0] o_value
);

   logic             valid_q, valid_d;
   logic [WIDTH-1:0] value_q, value_d;

   // A load wins over a take so a same-cycle take and refill keeps the slot full.
   always_comb begin
      valid_d = valid_q;
      value_d = value_q;
      if (i_load) begin
         valid_d = 1'b1;
         value_d = i_value;
      end else if (valid_q && i_ready) begin
         valid_d = 1'b0;
         value_d = DEFAULT;
      end
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         valid_q <= 1'b0;
         value_q <= DEFAULT;
      end else begin
         valid_q <= valid_d;
         value_q <= value_d;
      end
   end

   assign o_valid = valid_q;
   assign o_value = value_q;

endmodule

// File: rtl/tnoc_stream_demux.sv
// Packet-level stream demultiplexer: routes each packet to the one-hot selected channel.
module tnoc_stream_demux
   import tnoc_stream_demux_pkg::*;
#(
   parameter int unsigned    WIDTH   = 8,
   parameter int unsigned    ENTRIES = 8,
   parameter bit [WIDTH-1:0] DEFAULT = '0
) (
   input  logic               i_clk,
   input  logic               i_rst,
   input  logic               i_valid,
   output logic               o_ready,
   input  logic [WIDTH-1:0]   i_value,
   input  logic               i_sop,
   input  logic               i_eop,
   input  logic [ENTRIES-1:0] i_select,
   output logic [ENTRIES-1:0] o_valid,
   input  logic [ENTRIES-1:0] i_ready,
   output logic [WIDTH-1:0]   o_value [ENTRIES],
   output logic               o_error
);

   demux_state_e       state_q;
   logic [ENTRIES-1:0] sel_q;
   logic               error_q;

   logic               sel_ok;
   logic [ENTRIES-1:0] tgt;
   logic               slot_free;
   logic               accept;
   logic               drop;
   logic [ENTRIES-1:0] load;

   always_comb begin
      sel_ok    = is_onehot(MaxEntries'(i_select));
      tgt       = (state_q == StRoute) ? sel_q : i_select;
      slot_free = |(tgt & (~o_valid | i_ready));

      unique case (state_q)
         StIdle:  o_ready = sel_ok ? slot_free : 1'b1;
         StRoute: o_ready = slot_free;
         StDrop:  o_ready = 1'b1;
         default: o_ready = 1'b0;
      endcase
      if (i_rst) o_ready = 1'b0;

      accept = i_valid && o_ready;
      load   = '0;
      if (accept) begin
         if (state_q == StRoute) begin
            load = sel_q;
         end else if (state_q == StIdle && i_sop && sel_ok) begin
            load = i_select;
         end
      end
      // Every accepted beat that lands in no slot is a drop.
      drop = accept && (load == '0);
   end

   always_ff @(posedge i_clk or posedge i_rst) begin
      if (i_rst) begin
         state_q <= StIdle;
         sel_q   <= '0;
         error_q <= 1'b0;
      end else begin
         error_q <= drop;
         if (accept) begin
            unique case (state_q)
               StIdle: begin
                  if (i_sop && sel_ok) begin
                     sel_q <= i_select;
                     if (!i_eop) state_q <= StRoute;
                  end else if (i_sop && !i_eop) begin
                     state_q <= StDrop;
                  end
               end
               StRoute, StDrop: begin
                  if (i_eop) state_q <= StIdle;
               end
               default: state_q <= StIdle;
            endcase
         end
      end
   end

   assign o_error = error_q;

   for (genvar g = 0; g < int'(ENTRIES); g++) begin : g_slot
      tnoc_demux_slot #(
         .WIDTH   (WIDTH),
         .DEFAULT (DEFAULT)
      ) u_slot (
         .i_clk   (i_clk),
         .i_rst   (i_rst),
         .i_load  (load[g]),
         .i_value (i_value),
         .i_ready (i_ready[g]),
         .o_valid (o_valid[g]),
         .o_value (o_value[g])
      );
   end

endmodule

// File: tb/tb_tnoc_stream_demux.sv
// Directed bench for tnoc_stream_demux with hand-computed expectations.
module tb_tnoc_stream_demux;

   localparam int unsigned    W   = 8;
   localparam int unsigned    N   = 8;
   localparam logic [W-1:0]   DEF = 8'h3C;

   logic         i_clk = 1'b0;
   logic         i_rst;
   logic         i_valid;
   logic         o_ready;
   logic [W-1:0] i_value;
   logic         i_sop;
   logic         i_eop;
   logic [N-1:0] i_select;
   logic [N-1:0] o_valid;
   logic [N-1:0] i_ready;
   logic [W-1:0] o_value [N];
   logic         o_error;

   int total = 0;
   int bad   = 0;

   tnoc_stream_demux #(
      .WIDTH   (W),
      .ENTRIES (N),
      .DEFAULT (DEF)
   ) dut (
      .i_clk    (i_clk),
      .i_rst    (i_rst),
      .i_valid  (i_valid),
      .o_ready  (o_ready),
      .i_value  (i_value),
      .i_sop    (i_sop),
      .i_eop    (i_eop),
      .i_select (i_select),
      .o_valid  (o_valid),
      .i_ready  (i_ready),
      .o_value  (o_value),
      .o_error  (o_error)
   );

   always #5 i_clk = ~i_clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      total++;
      if (got !== exp) begin
         bad++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   // Advance past the next rising edge; outputs are then stable for sampling.
   task automatic cyc();
      @(posedge i_clk);
      #1;
   endtask

   task automatic beat(input logic [N-1:0] sel, input logic [W-1:0] val,
                       input logic sop, input logic eop);
      i_valid  = 1'b1;
      i_select = sel;
      i_value  = val;
      i_sop    = sop;
      i_eop    = eop;
   endtask

   initial begin
      i_rst = 1'b1; i_valid = 1'b0; i_value = '0; i_sop = 1'b0; i_eop = 1'b0;
      i_select = '0; i_ready = '0;
      cyc(); cyc();
      check("rst_ready", 32'(o_ready), 32'd0);
      check("rst_valid", 32'(o_valid), 32'd0);
      check("rst_value0", 32'(o_value[0]), 32'(DEF));
      check("rst_error", 32'(o_error), 32'd0);
      i_rst = 1'b0;
      cyc();

      // Single-beat packet to channel 2
      beat(8'h04, 8'hA5, 1'b1, 1'b1);
      #1 check("single_ready", 32'(o_ready), 32'd1);
      cyc();
      i_valid = 1'b0;
      check("single_valid", 32'(o_valid), 32'h04);
      check("single_value2", 32'(o_value[2]), 32'hA5);
      check("single_value0", 32'(o_value[0]), 32'(DEF));
      check("single_value7", 32'(o_value[7]), 32'(DEF));
      check("single_error", 32'(o_error), 32'd0);
      i_ready = 8'h04;
      cyc();
      check("single_drained", 32'(o_valid), 32'd0);
      check("single_reload", 32'(o_value[2]), 32'(DEF));
      i_ready = '0;

      // 4-beat packet to channel 5, select/sop perturbed mid-packet
      i_ready = 8'h20;
      for (int i = 0; i < 4; i++) begin
         if (i == 0) beat(8'h20, 8'h10, 1'b1, 1'b0);
         else        beat(8'h01, 8'(8'h10 + i), (i == 2), (i == 3));
         #1 check("burst_ready", 32'(o_ready), 32'd1);
         cyc();
         check("burst_valid", 32'(o_valid), 32'h20);
         check("burst_value5", 32'(o_value[5]), 32'(8'h10 + i));
      end
      i_valid = 1'b0;
      cyc();
      check("burst_drained", 32'(o_valid), 32'd0);

      // Backpressure on channel 5
      i_ready = '0;
      beat(8'h20, 8'h40, 1'b1, 1'b0);
      #1 check("bp_ready0", 32'(o_ready), 32'd1);
      cyc();
      beat(8'h20, 8'h41, 1'b0, 1'b1);
      #1 check("bp_stall", 32'(o_ready), 32'd0);
      cyc();
      check("bp_hold_valid", 32'(o_valid), 32'h20);
      check("bp_hold_value", 32'(o_value[5]), 32'h40);
      i_ready = 8'h20;
      #1 check("bp_release", 32'(o_ready), 32'd1);
      cyc();
      i_valid = 1'b0;
      check("bp_refill_valid", 32'(o_valid), 32'h20);
      check("bp_refill_value", 32'(o_value[5]), 32'h41);
      cyc();
      check("bp_drained", 32'(o_valid), 32'd0);
      i_ready = '0;

      // Multi-hot select: 3 dropped beats
      for (int i = 0; i < 3; i++) begin
         beat(8'h03, 8'(8'h60 + i), (i == 0), (i == 2));
         #1 check("drop_ready", 32'(o_ready), 32'd1);
         cyc();
         check("drop_error", 32'(o_error), 32'd1);
         check("drop_valid", 32'(o_valid), 32'd0);
      end
      i_valid = 1'b0;
      cyc();
      check("drop_error_end", 32'(o_error), 32'd0);

      // Stray sop=0 beat in idle, then a legal packet
      beat(8'h02, 8'h77, 1'b0, 1'b0);
      cyc();
      check("stray_error", 32'(o_error), 32'd1);
      check("stray_valid", 32'(o_valid), 32'd0);
      beat(8'h02, 8'h88, 1'b1, 1'b1);
      cyc();
      i_valid = 1'b0;
      check("after_stray_error", 32'(o_error), 32'd0);
      check("after_stray_valid", 32'(o_valid), 32'h02);
      check("after_stray_value1", 32'(o_value[1]), 32'h88);
      i_ready = 8'h02;
      cyc();
      i_ready = '0;

      // Reset in the middle of a packet to channel 3
      beat(8'h08, 8'hB0, 1'b1, 1'b0);
      cyc();
      check("pre_rst_valid", 32'(o_valid), 32'h08);
      beat(8'h08, 8'hB1, 1'b0, 1'b0);
      #1 i_rst = 1'b1;
      #1;
      check("mid_rst_valid", 32'(o_valid), 32'd0);
      check("mid_rst_value3", 32'(o_value[3]), 32'(DEF));
      check("mid_rst_ready", 32'(o_ready), 32'd0);
      check("mid_rst_error", 32'(o_error), 32'd0);
      cyc();
      i_rst = 1'b0;
      i_valid = 1'b0;
      cyc();
      // In IDLE a sop=0 beat must be dropped, not routed to channel 3
      beat(8'h08, 8'hD0, 1'b0, 1'b0);
      cyc();
      check("post_rst_stray_error", 32'(o_error), 32'd1);
      check("post_rst_stray_valid", 32'(o_valid), 32'd0);
      beat(8'h10, 8'hC4, 1'b1, 1'b1);
      cyc();
      i_valid = 1'b0;
      check("post_rst_valid", 32'(o_valid), 32'h10);
      check("post_rst_value4", 32'(o_value[4]), 32'hC4);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/tnoc_stream_demux.md
TNOC_STREAM_DEMUX -- requirements
Module: tnoc_stream_demux

Interface
REQ-001 SHALL have parameter WIDTH, default 8: payload bits per beat.
REQ-002 SHALL have parameter ENTRIES, default 8: number of output channels, legal range 2..32.
REQ-003 SHALL have parameter DEFAULT, bit [WIDTH-1:0], default '0: payload value driven on an output channel whose slot is empty.
REQ-004 SHALL have port i_clk, input, 1: the single clock; all state is on its rising edge.
REQ-005 SHALL have port i_rst, input, 1: reset, asynchronous and active-high.
REQ-006 SHALL have ports i_valid (input, 1), o_ready (output, 1), i_value (input, WIDTH), i_sop (input, 1), i_eop (input, 1): input beat handshake, payload, start-of-packet flag and end-of-packet flag.
REQ-007 SHALL have port i_select, input, ENTRIES: one-hot channel select, sampled only on a start-of-packet beat.
REQ-008 SHALL have ports o_valid (output, ENTRIES), i_ready (input, ENTRIES) and o_value (output, WIDTH x [ENTRIES] unpacked): per-channel output handshake and payload.
REQ-009 SHALL have port o_error, output, 1: one-cycle pulse for each dropped beat.

Function
- REQ-010 An input beat is accepted when i_valid && o_ready, and an output beat on channel k is taken when o_valid[k] && i_ready[k].
- REQ-011 Each channel SHALL own a one-entry output register, so latency from input accept to o_valid is exactly 1 cycle.
- REQ-012 o_value[k] SHALL equal DEFAULT whenever o_valid[k]=0; a drained slot with no refill in the same cycle reloads DEFAULT.
- REQ-013 The FSM SHALL have 3 states: IDLE, ROUTE, DROP.
- REQ-014 IDLE, accepted beat with i_sop=1 and i_select one-hot:
  - route the beat to the selected channel;
  - latch the select;
  - go to ROUTE if i_eop=0, otherwise stay in IDLE.
- REQ-015 IDLE, accepted beat with i_sop=1 and i_select zero or multi-hot: drop the beat, pulse o_error, go to DROP if i_eop=0.
- REQ-016 IDLE, accepted beat with i_sop=0: drop the beat, pulse o_error, stay in IDLE.
- REQ-017 ROUTE: each accepted beat goes to the latched channel and i_sop/i_select are ignored; an i_eop=1 beat returns the FSM to IDLE.
- REQ-018 DROP: every beat is accepted and discarded with an o_error pulse; an i_eop=1 beat returns the FSM to IDLE.
- REQ-019 o_ready SHALL be:
  - in ROUTE, 1 iff the latched slot is empty or being taken this cycle (i_ready[k]=1);
  - in IDLE with a one-hot select, the same test applied to the selected slot;
  - in IDLE with an illegal select, and in DROP, 1.
- REQ-020 o_ready SHALL not depend on i_valid, and o_valid[k] SHALL not depend on i_ready[k].
- REQ-021 A simultaneous take and refill on one slot SHALL keep o_valid[k]=1 with the new payload, giving full throughput of 1 beat/cycle per packet.
- REQ-022 Slots on other channels SHALL drain independently while a packet is routed elsewhere.
- REQ-023 At most one o_valid bit SHALL rise per cycle.

Reset
- REQ-024 Asserting i_rst at any time, including mid-packet, SHALL asynchronously force:
  - FSM to IDLE;
  - all o_valid to 0;
  - all o_value to DEFAULT;
  - latched select to 0;
  - o_error to 0.
- REQ-025 o_ready SHALL be 0 while i_rst=1, and in-flight beats are lost.

Structure
- REQ-026 The state enum and a one-hot check function SHALL live in shared package tnoc_stream_demux_pkg.
- REQ-027 The per-channel slot SHALL be sub-module tnoc_demux_slot (WIDTH, DEFAULT), instantiated ENTRIES times in a generate loop.

Verification
- REQ-028 Single-beat packet, sop=eop=1, select=0000_0100, payload 8'hA5 -> o_valid[2]=1 with o_value[2]=8'hA5 on the next cycle; all other o_value = DEFAULT.
- REQ-029 4-beat packet to channel 5 with i_ready[5]=1 and select changed mid-packet -> 4 consecutive beats on channel 5 only, o_ready constant 1.
- REQ-030 i_ready[5]=0 with slot 5 full -> o_ready=0 and i_value held; i_ready[5]=1 -> exactly one-cycle stall, no beat lost or duplicated.
- REQ-031 select=0000_0011 on a 3-beat packet -> 3 o_error pulses, o_valid stays 0, FSM in IDLE after the eop beat.
- REQ-032 Beat with sop=0 in IDLE -> one o_error pulse; the next legal packet routes normally.
- REQ-033 i_rst asserted during beat 2 of a packet -> outputs go to their reset values immediately; after release a new packet routes correctly and no ROUTE state remains.
